// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle core control FSM sitting behind the instruction decoder.
//   Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
//   drives the icache/dcache request handshakes and the IR/PC/regfile write
//   strobes, counts retired instructions and halts on an illegal opcode or
//   a memory wait timeout.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   imem_ready          icache instruction word valid
//   dmem_ready          dcache access complete
//   alu_operation, write_register, load_word_memory, store_word_memory,
//   branch, jump, panic decoder flags (valid from DECODE until next ir_write)
//   branch_taken        ALU compare result, valid in EXECUTE
//   imem_req, ir_write  fetch request / instruction register latch
//   dmem_req, dmem_we   data access request / 1 = store
//   pc_write, pc_sel    PC update / 0 = PC+4, 1 = target
//   rf_write, wb_sel    regfile write / 00 ALU, 01 mem, 10 PC+4
//   state               FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 HALT=5
//   halted, timeout_err in HALT / HALT entered through a timeout (sticky)
//   instret             retired-instruction count, wraps
module multicycle_sequencer #(
  parameter int unsigned INSTRET_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  input  logic                     alu_operation,
  input  logic                     write_register,
  input  logic                     load_word_memory,
  input  logic                     store_word_memory,
  input  logic                     branch,
  input  logic                     jump,
  input  logic                     panic,
  input  logic                     branch_taken,
  output logic                     imem_req,
  output logic                     ir_write,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic                     pc_write,
  output logic                     pc_sel,
  output logic                     rf_write,
  output logic [1:0]               wb_sel,
  output logic [2:0]               state,
  output logic                     halted,
  output logic                     timeout_err,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // The counter never has to hold TIMEOUT itself: the cycle that would reach
  // it leaves the state, which clears the counter.
  localparam int unsigned   WCW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(TIMEOUT - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [WCW-1:0]           r_wait_cnt;
  logic [INSTRET_WIDTH-1:0] r_instret;
  logic                     r_timeout_err;
  logic                     w_wait;
  logic                     w_timeout;
  logic                     w_at_limit;
  logic                     w_unused_flags;

  // ALU-type instructions take the default WRITEBACK path, so the flag
  // itself does not steer the sequencer.
  assign w_unused_flags = alu_operation;

  assign w_at_limit  = (TIMEOUT != 0) && (r_wait_cnt == W_LAST);
  assign state       = r_state;
  assign instret     = r_instret;
  assign timeout_err = r_timeout_err;

  always_comb begin
    w_next    = r_state;
    w_wait    = 1'b0;
    w_timeout = 1'b0;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    rf_write  = 1'b0;
    wb_sel    = 2'b00;
    halted    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else begin
          w_wait = 1'b1;
          if (w_at_limit) begin
            w_next    = S_HALT;
            w_timeout = 1'b1;
          end
        end
      end
      S_DECODE: w_next = panic ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (load_word_memory || store_word_memory) begin
          w_next = S_MEMORY;
        end else if (branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = store_word_memory;
        if (dmem_ready) begin
          if (store_word_memory) begin
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else begin
          w_wait = 1'b1;
          if (w_at_limit) begin
            w_next    = S_HALT;
            w_timeout = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        rf_write = write_register;
        pc_write = 1'b1;
        pc_sel   = jump;
        wb_sel   = jump ? 2'b10 : (load_word_memory ? 2'b01 : 2'b00);
        w_next   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_instret     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (pc_write) begin
        r_instret <= r_instret + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Self-checking bench: each issued instruction pushes its expected retire
//   record to a queue; a negedge monitor pops it when pc_write is seen.
module tb_multicycle_sequencer;

  localparam int K_ADD = 0, K_LOAD = 1, K_STORE = 2, K_BRT = 3, K_BRN = 4, K_JAL = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic alu_operation = 1'b0, write_register = 1'b0, load_word_memory = 1'b0;
  logic store_word_memory = 1'b0, branch = 1'b0, jump = 1'b0, panic = 1'b0;
  logic branch_taken = 1'b0;
  logic imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, rf_write;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic halted, timeout_err;
  logic [3:0] instret;
  logic [7:0] strobes;

  assign strobes = {ir_write, dmem_req, dmem_we, pc_write, pc_sel, rf_write, wb_sel};

  multicycle_sequencer #(.INSTRET_WIDTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_operation(alu_operation), .write_register(write_register),
    .load_word_memory(load_word_memory), .store_word_memory(store_word_memory),
    .branch(branch), .jump(jump), .panic(panic), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .pc_sel(pc_sel), .rf_write(rf_write), .wb_sel(wb_sel),
    .state(state), .halted(halted), .timeout_err(timeout_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       psel;
    logic       rf;
    logic [1:0] wb;
  } ret_t;

  ret_t       sb[$];
  logic [2:0] trace[$];
  logic       tracing = 1'b0;
  logic       exp_we = 1'b0;
  int         n_ret = 0;
  int         n_dreq = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ret_t exp_for(input int kind);
    ret_t e;
    case (kind)
      K_ADD:   e = '{3'd4, 1'b0, 1'b1, 2'b00};
      K_LOAD:  e = '{3'd4, 1'b0, 1'b1, 2'b01};
      K_STORE: e = '{3'd3, 1'b0, 1'b0, 2'b00};
      K_BRT:   e = '{3'd2, 1'b1, 1'b0, 2'b00};
      K_BRN:   e = '{3'd2, 1'b0, 1'b0, 2'b00};
      default: e = '{3'd4, 1'b1, 1'b1, 2'b10};
    endcase
    return e;
  endfunction

  task automatic set_flags(input int kind);
    alu_operation     = (kind == K_ADD);
    write_register    = (kind == K_ADD) || (kind == K_LOAD) || (kind == K_JAL);
    load_word_memory  = (kind == K_LOAD);
    store_word_memory = (kind == K_STORE);
    branch            = (kind == K_BRT) || (kind == K_BRN);
    branch_taken      = (kind == K_BRT);
    jump              = (kind == K_JAL);
    panic             = 1'b0;
    exp_we            = (kind == K_STORE);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    n_ret = 0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // Issue one instruction from FETCH; imem answers after idly wait cycles,
  // dmem after ddly wait cycles. Returns once the FSM is back in FETCH.
  task automatic do_instr(input int kind, input int idly, input int ddly);
    int n;
    int mc;
    set_flags(kind);
    sb.push_back(exp_for(kind));
    for (int i = 0; i < idly; i++) tick();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    n = 0;
    mc = 0;
    while (state != 3'd0 && n < 20) begin
      if (state == 3'd3) begin
        dmem_ready = (mc >= ddly);
        mc++;
      end else begin
        dmem_ready = 1'b0;
      end
      tick();
      n++;
    end
    dmem_ready = 1'b0;
    check("instr_back_to_fetch", n < 20, 1);
  endtask

  // Bring a load into MEMORY with dmem never answering.
  task automatic load_to_memory();
    int n;
    set_flags(K_LOAD);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      tick();
      n++;
    end
    check("reach_memory", state, 3'd3);
  endtask

  always @(negedge clk) begin : monitor
    ret_t e;
    if (tracing) trace.push_back(state);
    if (dmem_req) begin
      n_dreq++;
      check("dmem_we", dmem_we, exp_we);
    end
    if (rf_write) check("rf_write_with_pc_write", pc_write, 1);
    if (!reset && pc_write) begin
      check("retire_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("retire_state", state, e.st);
        check("retire_pc_sel", pc_sel, e.psel);
        check("retire_rf_write", rf_write, e.rf);
        check("retire_wb_sel", wb_sel, e.wb);
      end
      check("instret_at_retire", instret, n_ret % 16);
      n_ret++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_add[6];
    logic [2:0] exp_rerun[7];
    exp_add   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
    exp_rerun = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};

    // Reset held two cycles
    reset = 1'b1;
    repeat (2) tick();
    check("rst_state", state, 3'd0);
    check("rst_strobes", strobes, 8'h00);
    check("rst_instret", instret, 4'd0);
    check("rst_halted", halted, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    check("fetch_imem_req", imem_req, 1);

    // ADD with imem two cycles late
    trace.delete();
    tracing = 1'b1;
    do_instr(K_ADD, 2, 0);
    tracing = 1'b0;
    check("add_trace_len", trace.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < trace.size()) check("add_trace", trace[i], exp_add[i]);
    check("add_instret", instret, 4'd1);

    // Load with dmem three cycles late (ready on the last allowed cycle)
    n_dreq = 0;
    do_instr(K_LOAD, 0, 3);
    check("load_dmem_req_cycles", n_dreq, 4);
    check("load_timeout_err", timeout_err, 0);

    // Branch taken / not taken, store, jump
    do_instr(K_BRT, 0, 0);
    do_instr(K_BRN, 1, 0);
    do_instr(K_STORE, 0, 2);
    do_instr(K_JAL, 0, 0);
    check("instret_after_six", instret, 4'd6);

    // Illegal instruction halts; ready pulses are ignored
    set_flags(K_ADD);
    panic = 1'b1;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("panic_decode", state, 3'd1);
    tick();
    check("panic_halt_state", state, 3'd5);
    check("panic_halted", halted, 1);
    for (int i = 0; i < 4; i++) begin
      imem_ready = i[0];
      dmem_ready = 1'b1;
      tick();
      check("halt_strobes", {imem_req, strobes}, 9'h000);
      check("halt_sticky", state, 3'd5);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    panic = 1'b0;
    do_reset(1);
    check("panic_reset_state", state, 3'd0);
    check("panic_reset_halted", halted, 0);

    // Fetch timeout after four wait cycles
    repeat (3) tick();
    check("fetch_wait3_state", state, 3'd0);
    tick();
    check("fetch_timeout_state", state, 3'd5);
    check("fetch_timeout_err", timeout_err, 1);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("timeout_err_sticky", timeout_err, 1);
    check("timeout_halt_sticky", state, 3'd5);
    do_reset(1);
    check("timeout_err_cleared", timeout_err, 0);

    // Rerun: ready on the fourth cycle wins over the timeout
    trace.delete();
    tracing = 1'b1;
    do_instr(K_ADD, 3, 0);
    tracing = 1'b0;
    check("rerun_trace_len", trace.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < trace.size()) check("rerun_trace", trace[i], exp_rerun[i]);
    check("rerun_timeout_err", timeout_err, 0);

    // Memory timeout
    load_to_memory();
    repeat (4) tick();
    check("mem_timeout_state", state, 3'd5);
    check("mem_timeout_err", timeout_err, 1);
    do_reset(1);

    // Reset in the middle of MEMORY
    load_to_memory();
    tick();
    reset = 1'b1;
    n_ret = 0;
    tick();
    check("midmem_reset_state", state, 3'd0);
    check("midmem_reset_dmem_req", dmem_req, 0);
    check("midmem_reset_instret", instret, 4'd0);
    reset = 1'b0;

    // Random mix past the 4-bit instret wrap
    for (int i = 0; i < 20; i++)
      do_instr($urandom_range(5, 0), $urandom_range(3, 0), $urandom_range(3, 0));
    check("wrap_instret", instret, 4'd4);
    check("wrap_timeout_err", timeout_err, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
